// File: rtl/aes_encipher_core.sv
// Iterative AES-128/256 encipher datapath: one column per cycle through an external
// S-box, with round keys returned combinationally for the registered round index.
module aes_encipher_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   word_q, word_d;
    logic [127:0] block_q, block_d;
    logic         keylen_q, keylen_d;
    logic [3:0]   num_rounds;
    logic [127:0] shifted;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (column c, row r) sits at bits [127-8*(4c+r) -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

    assign num_rounds = keylen_q ? 4'd14 : 4'd10;
    assign shifted    = shift_rows(block_q);

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= IDLE;
            round_q  <= '0;
            word_q   <= '0;
            block_q  <= '0;
            keylen_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            round_q  <= round_d;
            word_q   <= word_d;
            block_q  <= block_d;
            keylen_q <= keylen_d;
        end
    end

    // NOTE: every combinational output is given a default first, so no latch is inferred.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (next) fsm_d = INIT;
            INIT:    fsm_d = SBOX;
            SBOX:    if (word_q == 2'd3) fsm_d = MAIN;
            MAIN:    fsm_d = (round_q == num_rounds) ? IDLE : SBOX;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        round_d  = round_q;
        word_d   = word_q;
        block_d  = block_q;
        keylen_d = keylen_q;
        case (fsm_q)
            IDLE: begin
                if (next) begin
                    keylen_d = keylen;
                    round_d  = '0;
                end
            end
            INIT: begin
                block_d = block ^ round_key;
                round_d = 4'd1;
                word_d  = '0;
            end
            SBOX: begin
                word_d = word_q + 2'd1;
                case (word_q)
                    2'd0: block_d[127:96] = new_sboxw;
                    2'd1: block_d[95:64]  = new_sboxw;
                    2'd2: block_d[63:32]  = new_sboxw;
                    2'd3: block_d[31:0]   = new_sboxw;
                endcase
            end
            MAIN: begin
                if (round_q == num_rounds) begin
                    block_d = shifted ^ round_key;
                end else begin
                    block_d = mix_columns(shifted) ^ round_key;
                    round_d = round_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (fsm_q == IDLE);
        sboxw = block_q[127:96];
        case (word_q)
            2'd0: sboxw = block_q[127:96];
            2'd1: sboxw = block_q[95:64];
            2'd2: sboxw = block_q[63:32];
            2'd3: sboxw = block_q[31:0];
        endcase
    end

    assign round     = round_q;
    assign new_block = block_q;

endmodule

// File: tb/tb_aes_encipher_core.sv
// Self-checking bench for aes_encipher_core: FIPS-197 vectors plus random keys and
// blocks against a byte-level AES model; the bench plays S-box and key memory.
`timescale 1ns/1ps
module tb_aes_encipher_core;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         next = 1'b0;
    logic         keylen = 1'b0;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block = '0;
    logic [127:0] new_block;
    logic         ready;

    logic [7:0]   sbox_tbl [256];
    logic [127:0] rk_tbl   [16];
    int           vectors = 0;
    int           miscompares = 0;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encipher_core dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    assign round_key = rk_tbl[round];
    assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                        sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};

    // GF(2^8) product: carry-less multiply, then long-division reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    // FIPS-197 key expansion into the key-memory table the DUT reads by round index.
    task automatic load_keys(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tbl[r] = '0;
        end
    endtask

    // Byte-array AES; byte index 4*col+row, byte 0 is the MSB of the block.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = pt ^ rk_tbl[0];
        for (int i = 0; i < 16; i++) s[i] = x[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r != nr)
                        s[4*c + row] = gmul(8'h02, t[4*c + row]) ^ gmul(8'h03, t[4*c + (row + 1) % 4])
                                     ^ t[4*c + (row + 2) % 4] ^ t[4*c + (row + 3) % 4];
                    else
                        s[4*c + row] = t[4*c + row];
            x = rk_tbl[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ x[127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) x[127 - 8*i -: 8] = s[i];
        return x;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the first negedge with ready=1.
    task automatic run_op(input logic [127:0] pt, input logic kl, input bit disturb,
                          output logic [127:0] ct, output int lat, output logic [127:0] first_nb);
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        lat    = 0;
        first_nb = 'x;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            next = 1'b0;
            if (cyc == 0) first_nb = new_block;
            if (ready === 1'b1) break;
            lat++;
            if (disturb && (lat == 7 || lat == 33)) begin
                next   = 1'b1;
                keylen = ~keylen;
                block  = ~block;
            end
        end
        ct = new_block;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, expected 1", ready); end
        vectors++;
        if (round !== 4'd0) begin miscompares++; $display("FAIL reset_round: got %0d, expected 0", round); end
        vectors++;
        if (new_block !== 128'h0) begin miscompares++; $display("FAIL reset_block: got %h, expected 0", new_block); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128(input bit disturb);
        logic [127:0] ct, nb;
        int lat;
        load_keys(KEY128, 1'b0);
        run_op(PT, 1'b0, disturb, ct, lat, nb);
        vectors++;
        if (ct !== CT128) begin miscompares++; $display("FAIL aes128_ct(disturb=%0d): got %h, expected %h", disturb, ct, CT128); end
        vectors++;
        if (lat !== 51) begin miscompares++; $display("FAIL aes128_latency(disturb=%0d): got %0d, expected 51", disturb, lat); end
    endtask

    task automatic test_aes256();
        logic [127:0] ct, nb;
        int lat;
        load_keys(KEY256, 1'b1);
        run_op(PT, 1'b1, 1'b0, ct, lat, nb);
        vectors++;
        if (ct !== CT256) begin miscompares++; $display("FAIL aes256_ct: got %h, expected %h", ct, CT256); end
        vectors++;
        if (lat !== 71) begin miscompares++; $display("FAIL aes256_latency: got %0d, expected 71", lat); end
    endtask

    task automatic test_idle_hold();
        logic [127:0] held;
        held = CT256;
        for (int i = 0; i < 6; i++) begin
            block  = {$urandom(), $urandom(), $urandom(), $urandom()};
            keylen = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (new_block !== held || ready !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_hold[%0d]: got block %h ready %b, expected %h ready 1", i, new_block, ready, held);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic [127:0] ct, nb;
        int lat;
        load_keys(KEY256, 1'b1);
        block  = PT;
        keylen = 1'b1;
        next   = 1'b1;
        @(negedge clk);
        next  = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (round === 4'd5) begin found = 1'b1; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (!found) begin miscompares++; $display("FAIL reset_mid_reach_round5: got round %0d, expected 5", round); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid_ready: got %b, expected 1", ready); end
        vectors++;
        if (round !== 4'd0) begin miscompares++; $display("FAIL reset_mid_round: got %0d, expected 0", round); end
        vectors++;
        if (new_block !== 128'h0) begin miscompares++; $display("FAIL reset_mid_block: got %h, expected 0", new_block); end
        reset = 1'b0;
        @(negedge clk);
        load_keys(KEY128, 1'b0);
        run_op(PT, 1'b0, 1'b0, ct, lat, nb);
        vectors++;
        if (ct !== CT128) begin miscompares++; $display("FAIL reset_mid_rerun_ct: got %h, expected %h", ct, CT128); end
        vectors++;
        if (lat !== 51) begin miscompares++; $display("FAIL reset_mid_rerun_latency: got %0d, expected 51", lat); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct, nb;
        int lat;
        load_keys(KEY128, 1'b0);
        run_op(PT, 1'b0, 1'b0, ct, lat, nb);
        vectors++;
        if (ct !== CT128) begin miscompares++; $display("FAIL b2b_first_ct: got %h, expected %h", ct, CT128); end
        load_keys(KEY256, 1'b1);
        run_op(PT, 1'b1, 1'b0, ct, lat, nb);
        vectors++;
        if (nb !== CT128) begin miscompares++; $display("FAIL b2b_hold_first: got %h, expected %h", nb, CT128); end
        vectors++;
        if (ct !== CT256) begin miscompares++; $display("FAIL b2b_second_ct: got %h, expected %h", ct, CT256); end
        vectors++;
        if (lat !== 71) begin miscompares++; $display("FAIL b2b_second_latency: got %0d, expected 71", lat); end
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] pt, exp_ct, ct, nb;
        logic         kl;
        int           lat;
        for (int n = 0; n < 8; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            kl  = 1'($urandom_range(0, 1));
            load_keys(key, kl);
            exp_ct = ref_encrypt(pt, kl ? 14 : 10);
            run_op(pt, kl, 1'($urandom_range(0, 1)), ct, lat, nb);
            vectors++;
            if (ct !== exp_ct) begin miscompares++; $display("FAIL random_ct[%0d] kl=%0d: got %h, expected %h", n, kl, ct, exp_ct); end
            vectors++;
            if (lat !== (kl ? 71 : 51)) begin miscompares++; $display("FAIL random_latency[%0d]: got %0d, expected %0d", n, lat, kl ? 71 : 51); end
        end
    endtask

    initial begin
        build_sbox();
        for (int r = 0; r < 16; r++) rk_tbl[r] = '0;
        test_reset();
        test_aes128(1'b0);
        test_aes256();
        test_idle_hold();
        test_aes128(1'b1);
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_encipher_core.md
Name: aes_encipher_core

Overview:
Iterative AES block encryption datapath for 128-bit and 256-bit keys. It processes one 32-bit column per cycle through an external 4-byte S-box, made of four aes_sbox byte instances outside this block. Round keys are not stored here: the block outputs the current round number, and an external key memory returns that round's key combinationally. It sits between the AES key memory / S-box and the top-level AES control.

Parameters:
None. Key length is selected at run time by keylen.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
next  in  1  start pulse; sampled only in IDLE
keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds)
round  out  4  current round index; drives the external key memory address
round_key  in  128  key for `round`; valid in the same cycle (combinational return)
sboxw  out  32  word sent to the external S-box (byte-wise, 4 bytes)
new_sboxw  in  32  S-box result for sboxw; combinational, same cycle
block  in  128  plaintext; sampled in INIT
new_block  out  128  state register; holds the ciphertext when ready=1
ready  out  1  1 = idle / result valid; 0 = busy

Behaviour:
- Reset values (synchronous, reset=1 at a clock edge):
  - FSM = IDLE, ready = 1, round = 0, word counter = 0.
  - State (new_block) = 0.
  - Reset overrides any operation in progress, including mid-encryption.
- State layout: 4 words w0..w3, with w0 = bits [127:96]. Each word is one column; its MSB byte is row 0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - On next=1: ready<=0, latch keylen, round<=0, go to INIT.
  - next=0: hold all state.
- INIT:
  - state <= block XOR round_key (round_key is round 0).
  - round<=1, word counter<=0, go to SBOX.
- SBOX (4 cycles):
  - sboxw = state word[word counter]; that word <= new_sboxw.
  - Counter increments. After word 3 the counter wraps to 0 and the FSM goes to MAIN.
- MAIN, when round < Nr (Nr = 10 or 14):
  - state <= AddRoundKey(MixColumns(ShiftRows(state)), round_key).
  - round<=round+1, go to SBOX.
- MAIN, when round == Nr:
  - state <= AddRoundKey(ShiftRows(state), round_key). No MixColumns.
  - ready<=1, go to IDLE.
- ShiftRows: row r of column c takes row r from column (c+r) mod 4.
- MixColumns: standard FIPS-197 GF(2^8) matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02]. xtime reduces by 0x1B.
- sboxw outside the SBOX state: drives state word[word counter]. Its value is don't-care for correctness.
- Timing, with next sampled at edge E0:
  - ready=0 from E0.
  - AES-128: ready returns to 1 at edge E0+51 (1 INIT + 10×(4 SBOX + 1 MAIN)).
  - AES-256: ready returns to 1 at edge E0+71.
- new_block is the live state register. It shows intermediate values while busy and is held stable in IDLE until the next start.
- next while busy is ignored. A change of keylen while busy has no effect.
- Back-to-back operation: next may be asserted in the first IDLE cycle after ready rises.
- round is the registered counter. The external key memory must return round_key within the same cycle.

Test Plan:
1. Reset -> ready=1, new_block=0, round=0.
2. AES-128 (FIPS-197 C.1) -> new_block=69c4e0d86a7b0430d8cdb78070b4c55a.
   - Round keys 0..10: 000102030405060708090a0b0c0d0e0f, d6aa74fdd2af72fadaa678f1d6ab76fe, b692cf0b643dbdf1be9bc5006830b3fe, b6ff744ed2c2c9bf6c590cbf0469bf41, 47f7f7bc95353e03f96c32bcfd058dfd, 3caaa3e8a99f9deb50f3af57adf622aa, 5e390f7df7a69296a7553dc10aa31f6b, 14f9701ae35fe28c440adf4d4ea9c026, 47438735a41c65b9e016baf4aebf7ad2, 549932d1f08557681093ed9cbe2c974e, 13111d7fe3944a17f307a78b4d2b30c5.
   - block=00112233445566778899aabbccddeeff, keylen=0, next pulsed for 1 cycle.
   - Also check ready low for exactly 51 cycles.
3. AES-256 (FIPS-197 C.3) -> new_block=8ea2b7ca516745bfeafc49904b496089, ready low for 71 cycles.
   - Same block, keylen=1.
   - Round keys 0..14: 000102…0f, 101112…1f, a573c29fa176c498a97fce93a572c09c, 1651a8cd0244beda1a5da4c10640bade, ae87dff00ff11b68a68ed5fb03fc1567, 6de1f1486fa54f9275f8eb5373b8518d, c656827fc9a799176f294cec6cd5598b, 3de23a75524775e727bf9eb45407cf39, 0bdc905fc27b0948ad5245a4c1871c2f, 45f5a66017b2d387300d4d33640a820a, 7ccff71cbeb4fe5413e6bbf0d261a7df, f01afafee7a82979d7a5644ab3afe640, 2541fe719bf500258813bbd55a721c0a, 4e5a6699a9f24fe07e572baacdf8cdea, 24fc79ccbf0979e9371ac23c6d68de36.
4. Pulse next and toggle keylen mid-encryption in test 2 -> result still 69c4e0d8…c55a, latency unchanged.
5. Assert reset during round 5 of test 3 -> next edge gives ready=1, round=0, new_block=0. A fresh AES-128 run afterwards gives the correct ciphertext.
6. Back-to-back: run test 2, then immediately test 3 -> both ciphertexts correct. new_block holds the first result until the second next.
